fft_stage_sequencer: RTL and testbench
======================================

// Module: fft_stage_sequencer
// PURPOSE
//  Control FSM that drives one shared radix-2 butterfly_unit through all stages of an
//  in-place N-point DIT FFT held in a dual-port sample RAM.
//  Each cycle it issues one butterfly: two read addresses and a twiddle index.
//  It delays those addresses to match datapath latency and produces the write-back strobes.
//  Sits between the top-level start/done handshake and the RAM + butterfly + twiddle ROM.
// PARAMETERS
//  LOG2N   4  log2 of FFT size; N = 2**LOG2N points, N/2 butterflies per stage.
//  BF_LAT  2  cycles from rd_en to write-back (RAM read + butterfly regs); legal range 1..8.
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         synchronous, active-low reset
//  start      in   1         single-cycle request; sampled only in IDLE/DONE
//  busy       out  1         high in RUN and STALL
//  done       out  1         high in DONE; held until next accepted start or reset
//  stage      out  LOG2N     current stage index 0..LOG2N-1
//  rd_en      out  1         butterfly issue strobe
//  rd_addr_a  out  LOG2N     upper-leg read address
//  rd_addr_b  out  LOG2N     lower-leg read address
//  tw_idx     out  LOG2N-1   twiddle index k for W_N^k
//  wr_en      out  1         write-back strobe; rd_en delayed BF_LAT cycles
//  wr_addr_a  out  LOG2N     rd_addr_a delayed BF_LAT cycles (receives A+WB)
//  wr_addr_b  out  LOG2N     rd_addr_b delayed BF_LAT cycles (receives A-WB)
// BEHAVIOUR
//  Reset (reset==0 at an edge):
//   - state goes to IDLE; all outputs 0; the delay line is cleared.
//   - Any in-flight write-backs are discarded, including on reset mid-run.
//  States IDLE, RUN, STALL, DONE:
//   - IDLE -start-> RUN; stage=0, bf_cnt=0.
//   - RUN: rd_en=1 every cycle; bf_cnt increments.
//     At bf_cnt==N/2-1 go to STALL; lat_cnt=0.
//   - STALL: rd_en=0 for exactly BF_LAT cycles so the stage's write-backs land
//     (read-after-write hazard between stages).
//     Then, if stage==LOG2N-1, go to DONE; else stage+1, bf_cnt=0, RUN.
//   - DONE -start-> RUN (restart; done drops in that same cycle). No start: stay in DONE.
//   - start is ignored while busy.
//  Address math for stage s, butterfly k (0..N/2-1):
//   - h = 2**s; j = k & (h-1); g = k >> s.
//   - rd_addr_a = g*2h + j; rd_addr_b = rd_addr_a + h.
//   - tw_idx = j << (LOG2N-1-s).
//   - All arithmetic is unsigned and modulo 2**LOG2N; no overflow is possible by construction.
//  Outputs:
//   - rd_* are registered, valid in the cycle rd_en=1.
//   - wr_* come from a BF_LAT-deep shift register.
//  Latency:
//   - Accepting start at edge T gives the first rd_en in cycle T+1.
//   - done rises at T+1+LOG2N*(N/2+BF_LAT); N=16, BF_LAT=2 gives 41.
//   - The last wr_en is the cycle before done.
//  Input data must already be in bit-reversed order in the RAM; output is in natural order.
// STRUCTURE
//  fft_pkg:
//   - seq_state_t enum {IDLE, RUN, STALL, DONE}.
//   - localparams for the stage and twiddle widths.
//   - function bitrev() used by the testbench.
//  Sub-module fft_addr_gen: combinational (stage, bf_cnt) -> (addr_a, addr_b, tw_idx).
//  The top file holds the FSM, counters and write-back delay line.
// TESTING
//  - Reset held 3 cycles, then released with no start:
//    all outputs 0, state stays IDLE.
//  - N=16, BF_LAT=2, start pulse:
//    - stage0 k=0 gives (0,1,tw0).
//    - stage1 k=1 gives (1,3,tw4).
//    - stage3 k=5 gives (5,13,tw5).
//    - Exactly 32 rd_en and 32 wr_en pulses; done at cycle 41.
//  - wr_addr_a/b equal rd_addr_a/b exactly 2 cycles earlier.
//    No rd_en in the 2 cycles after each stage's last issue.
//  - start pulsed at cycle 10 of a run: ignored, and done timing is unchanged.
//  - reset=0 at cycle 20 of a run:
//    next cycle is IDLE, wr_en=0 and no stale write-back appears.
//    A later start gives a clean 41-cycle run.
//  - From DONE, a new start: done falls and the second run matches the first cycle-for-cycle.
//  - End to end: impulse loaded at RAM[0] with the real butterfly; all 16 outputs equal within 1 LSB.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 DIT FFT stage sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int LOG2N_DEF  = 4;
  localparam int BF_LAT_DEF = 2;
  localparam int STAGE_W    = LOG2N_DEF;
  localparam int TW_W       = LOG2N_DEF - 1;

  // Bit-reverse the low nbits of v; gives the RAM slot for natural-order sample v.
  function automatic int unsigned bitrev(input int unsigned v, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int i = 0; i < int'(nbits); i++) begin
      r = (r << 1) | ((v >> i) & 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle generator: (stage s, butterfly k) -> (a, a+2**s, twiddle k).
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = STAGE_W
) (
  input  logic [LOG2N-1:0] i_stage,
  input  logic [LOG2N-2:0] i_bf_cnt,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [LOG2N-2:0] o_tw_idx
);

  logic [LOG2N-2:0] w_mask;
  logic [LOG2N-2:0] w_j;
  logic [LOG2N-1:0] w_g;
  logic [LOG2N-1:0] w_h;
  logic [LOG2N-1:0] w_tw_sh;

  // Mask keeps the low s bits of k (position inside the butterfly group).
  assign w_mask   = ~({(LOG2N-1){1'b1}} << i_stage);
  assign w_j      = i_bf_cnt & w_mask;
  assign w_g      = {1'b0, i_bf_cnt} >> i_stage;
  assign w_h      = LOG2N'(1) << i_stage;
  assign w_tw_sh  = LOG2N'(LOG2N-1) - i_stage;

  assign o_addr_a = (w_g << (i_stage + LOG2N'(1))) | {1'b0, w_j};
  assign o_addr_b = o_addr_a + w_h;
  assign o_tw_idx = w_j << w_tw_sh;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer: issues N/2 butterflies per stage, stalls BF_LAT cycles between stages
// so write-backs land, and delays the issue addresses into write-back strobes.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N  = STAGE_W,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG2N-1:0] o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_idx,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b,
  output logic [1:0]       o_dbg_state
);

  localparam int NH    = 2 ** (LOG2N - 1);
  localparam int LAT_W = $clog2(BF_LAT + 1);

  // start is a one-cycle request honoured only in IDLE/DONE; done stays high
  // until the next accepted start, and busy covers every issue and stall cycle.
  seq_state_t       r_state;
  logic [LOG2N-1:0] r_stage;
  logic [LOG2N-1:0] r_bf;
  logic [LAT_W-1:0] r_lat;
  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic [LOG2N-1:0] r_rd_a;
  logic [LOG2N-1:0] r_rd_b;
  logic [LOG2N-2:0] r_tw;
  logic             r_dly_en [BF_LAT];
  logic [LOG2N-1:0] r_dly_a  [BF_LAT];
  logic [LOG2N-1:0] r_dly_b  [BF_LAT];

  logic [LOG2N-1:0] w_issue_stage;
  logic [LOG2N-2:0] w_issue_bf;
  logic [LOG2N-1:0] w_gen_a;
  logic [LOG2N-1:0] w_gen_b;
  logic [LOG2N-2:0] w_gen_tw;
  logic             w_last_stage;
  logic             w_lat_done;

  // r_bf counts the next butterfly to issue; leaving STALL issues k=0 of the next stage.
  assign w_issue_stage = (r_state == STALL) ? r_stage + LOG2N'(1) : r_stage;
  assign w_issue_bf    = (r_state == STALL) ? '0 : r_bf[LOG2N-2:0];
  assign w_last_stage  = (r_stage == LOG2N'(LOG2N - 1));
  assign w_lat_done    = (r_lat == LAT_W'(BF_LAT - 1));

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .i_stage  (w_issue_stage),
    .i_bf_cnt (w_issue_bf),
    .o_addr_a (w_gen_a),
    .o_addr_b (w_gen_b),
    .o_tw_idx (w_gen_tw)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_bf    <= '0;
      r_lat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_tw    <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_stage <= '0;
            r_bf    <= LOG2N'(1);
            r_rd_en <= 1'b1;
            r_rd_a  <= w_gen_a;
            r_rd_b  <= w_gen_b;
            r_tw    <= w_gen_tw;
          end
        end
        RUN: begin
          if (r_bf == LOG2N'(NH)) begin
            r_state <= STALL;
            r_lat   <= '0;
          end else begin
            r_bf    <= r_bf + LOG2N'(1);
            r_rd_en <= 1'b1;
            r_rd_a  <= w_gen_a;
            r_rd_b  <= w_gen_b;
            r_tw    <= w_gen_tw;
          end
        end
        STALL: begin
          if (!w_lat_done) begin
            r_lat <= r_lat + LAT_W'(1);
          end else if (w_last_stage) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_stage <= '0;
            r_bf    <= '0;
          end else begin
            r_state <= RUN;
            r_stage <= r_stage + LOG2N'(1);
            r_bf    <= LOG2N'(1);
            r_rd_en <= 1'b1;
            r_rd_a  <= w_gen_a;
            r_rd_b  <= w_gen_b;
            r_tw    <= w_gen_tw;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset flushes the delay line so no stale write-back survives an aborted run.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      for (int i = 0; i < BF_LAT; i++) begin
        r_dly_en[i] <= 1'b0;
        r_dly_a[i]  <= '0;
        r_dly_b[i]  <= '0;
      end
    end else begin
      r_dly_en[0] <= r_rd_en;
      r_dly_a[0]  <= r_rd_a;
      r_dly_b[0]  <= r_rd_b;
      for (int i = 1; i < BF_LAT; i++) begin
        r_dly_en[i] <= r_dly_en[i-1];
        r_dly_a[i]  <= r_dly_a[i-1];
        r_dly_b[i]  <= r_dly_b[i-1];
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_stage     = r_stage;
  assign o_rd_en     = r_rd_en;
  assign o_rd_addr_a = r_rd_a;
  assign o_rd_addr_b = r_rd_b;
  assign o_tw_idx    = r_tw;
  assign o_wr_en     = r_dly_en[BF_LAT-1];
  assign o_wr_addr_a = r_dly_a[BF_LAT-1];
  assign o_wr_addr_b = r_dly_b[BF_LAT-1];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: per-cycle reference model, directed and random runs,
// mid-run reset, and an end-to-end impulse FFT through a behavioural RAM + butterfly.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  localparam int LOG2N  = 4;
  localparam int BF_LAT = 2;
  localparam int N      = 16;
  localparam int NH     = N / 2;
  localparam int P      = NH + BF_LAT;
  localparam int TOTAL  = LOG2N * P;

  logic             clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_start = 1'b0;
  logic             o_busy, o_done, o_rd_en, o_wr_en;
  logic [LOG2N-1:0] o_stage, o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [LOG2N-2:0] o_tw_idx;
  logic [1:0]       o_dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(LOG2N), .BF_LAT(BF_LAT)) dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_stage     (o_stage),
    .o_rd_en     (o_rd_en),
    .o_rd_addr_a (o_rd_addr_a),
    .o_rd_addr_b (o_rd_addr_b),
    .o_tw_idx    (o_tw_idx),
    .o_wr_en     (o_wr_en),
    .o_wr_addr_a (o_wr_addr_a),
    .o_wr_addr_b (o_wr_addr_b),
    .o_dbg_state (o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_t = cycles since the accepting edge (1 = first issue cycle).
  bit m_active = 1'b0;
  int m_t      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) begin
    if (!i_reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (i_start && (!m_active || m_t > TOTAL)) begin
      m_active <= 1'b1;
      m_t      <= 1;
    end else if (m_active) begin
      m_t <= m_t + 1;
    end
  end

  function automatic void model_issue(input int t, output bit en, output int a,
                                      output int b, output int tw);
    int idx, s, r, h;
    en = 1'b0; a = 0; b = 0; tw = 0;
    if (t < 1) return;
    idx = t - 1;
    s   = idx / P;
    r   = idx % P;
    if (s >= LOG2N || r >= NH) return;
    h  = 1 << s;
    en = 1'b1;
    a  = (r / h) * 2 * h + (r % h);
    b  = a + h;
    tw = (r % h) * (NH / h);
  endfunction

  always @(negedge clk) begin
    bit busy_e, done_e, rd_e, wr_e;
    int a_e, b_e, tw_e, wa_e, wb_e, wt_e, stage_e, st_e;
    if (chk_en) begin
      busy_e = 1'b0; done_e = 1'b0; rd_e = 1'b0; wr_e = 1'b0;
      a_e = 0; b_e = 0; tw_e = 0; wa_e = 0; wb_e = 0; wt_e = 0;
      if (m_active) begin
        busy_e = (m_t >= 1 && m_t <= TOTAL);
        done_e = (m_t > TOTAL);
        model_issue(m_t, rd_e, a_e, b_e, tw_e);
        model_issue(m_t - BF_LAT, wr_e, wa_e, wb_e, wt_e);
      end
      stage_e = busy_e ? (m_t - 1) / P : 0;
      st_e = !m_active ? int'(IDLE) : done_e ? int'(DONE) : rd_e ? int'(RUN) : int'(STALL);
      check("busy", o_busy, busy_e);
      check("done", o_done, done_e);
      check("stage", o_stage, stage_e);
      check("state", o_dbg_state, st_e);
      check("rd_en", o_rd_en, rd_e);
      check("wr_en", o_wr_en, wr_e);
      if (rd_e) begin
        check("rd_addr_a", o_rd_addr_a, a_e);
        check("rd_addr_b", o_rd_addr_b, b_e);
        check("tw_idx", o_tw_idx, tw_e);
      end
      if (wr_e) begin
        check("wr_addr_a", o_wr_addr_a, wa_e);
        check("wr_addr_b", o_wr_addr_b, wb_e);
      end
    end
  end

  // ---------------- RAM + butterfly model (scoreboard for end-to-end) ----------------
  int ram_re [N];
  int ram_im [N];
  int w_re [NH];
  int w_im [NH];
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    int ar, ai, br, bi, tr, ti;
    logic [127:0] v;
    if (chk_en) begin
      if (!m_active) begin
        exp_q.delete();
      end else begin
        if (o_wr_en) begin
          if (exp_q.size() == 0) begin
            check("wq_underflow", 1, 0);
          end else begin
            v = exp_q.pop_front();
            ram_re[o_wr_addr_a] = int'(v[127:96]);
            ram_im[o_wr_addr_a] = int'(v[95:64]);
            ram_re[o_wr_addr_b] = int'(v[63:32]);
            ram_im[o_wr_addr_b] = int'(v[31:0]);
          end
        end
        if (o_rd_en) begin
          ar = ram_re[o_rd_addr_a]; ai = ram_im[o_rd_addr_a];
          br = ram_re[o_rd_addr_b]; bi = ram_im[o_rd_addr_b];
          tr = (br * w_re[o_tw_idx] - bi * w_im[o_tw_idx] + 8192) >>> 14;
          ti = (br * w_im[o_tw_idx] + bi * w_re[o_tw_idx] + 8192) >>> 14;
          exp_q.push_back({32'(ar + tr), 32'(ai + ti), 32'(ar - tr), 32'(ai - ti)});
        end
      end
    end
  end

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; runs one full transform, optionally pulsing start mid-run.
  task automatic do_run(input int spur_at, input bit rand_spur, input string tag);
    int rd_n, wr_n, done_at;
    rd_n = 0; wr_n = 0; done_at = 0;
    i_start = 1'b1;
    for (int c = 1; c <= TOTAL + 20 && done_at == 0; c++) begin
      @(negedge clk);
      if (o_rd_en) rd_n++;
      if (o_wr_en) wr_n++;
      if (o_done) done_at = c;
      i_start = (c <= TOTAL) &&
                ((c == spur_at) || (rand_spur && $urandom_range(0, 5) == 0));
    end
    i_start = 1'b0;
    check({tag, "_done_at"}, done_at, TOTAL + 1);
    check({tag, "_rd_pulses"}, rd_n, LOG2N * NH);
    check({tag, "_wr_pulses"}, wr_n, LOG2N * NH);
  endtask

  // Starts a run and pulls reset low at cycle rst_at of it.
  task automatic aborted_run(input int rst_at, input string tag);
    i_start = 1'b1;
    for (int c = 1; c <= rst_at; c++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    i_reset = 1'b0;
    @(negedge clk);
    check({tag, "_wr_after_rst"}, o_wr_en, 0);
    check({tag, "_state_after_rst"}, o_dbg_state, int'(IDLE));
    i_reset = 1'b1;
    repeat (BF_LAT + 2) @(negedge clk);
  endtask

  initial begin
    real pi;
    pi = 3.14159265358979;
    for (int k = 0; k < NH; k++) begin
      w_re[k] = $rtoi($floor(16384.0 * $cos(2.0 * pi * k / N) + 0.5));
      w_im[k] = $rtoi($floor(-16384.0 * $sin(2.0 * pi * k / N) + 0.5));
    end
    for (int i = 0; i < N; i++) begin
      ram_re[i] = 0;
      ram_im[i] = 0;
    end

    i_reset = 1'b0;
    i_start = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_rd_a", o_rd_addr_a, 0);
    check("idle_rd_b", o_rd_addr_b, 0);
    check("idle_tw", o_tw_idx, 0);
    check("idle_wr_a", o_wr_addr_a, 0);
    check("idle_wr_b", o_wr_addr_b, 0);

    do_run(10, 1'b0, "run1");
    repeat (3) @(negedge clk);
    do_run(0, 1'b0, "run2");
    repeat (2) @(negedge clk);

    aborted_run(20, "abort");
    do_run(0, 1'b0, "run3");

    for (int i = 0; i < N; i++) begin
      ram_re[i] = 0;
      ram_im[i] = 0;
    end
    ram_re[fft_pkg::bitrev(0, LOG2N)] = 1000;
    do_run(0, 1'b0, "impulse");
    for (int i = 0; i < N; i++) begin
      check("imp_re", (iabs(ram_re[i] - 1000) <= 1) ? 1000 : ram_re[i], 1000);
      check("imp_im", (iabs(ram_im[i]) <= 1) ? 0 : ram_im[i], 0);
    end

    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        aborted_run($urandom_range(1, TOTAL), "rnd_abort");
      end else begin
        do_run(0, 1'b1, "rnd");
      end
    end
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
